// File: rtl/grid_tile_locator.sv
// Maps VGA scan position onto a COLS x ROWS grid of equal tiles.
// Two-stage pipeline: S1 locates the tile, S2 forms the ROM address from a per-line offset.
module grid_tile_locator #(
    parameter int CNTR_WIDTH_H       = 11,
    parameter int CNTR_WIDTH_V       = 10,
    parameter int ROM_ADDR_BUS_WIDTH = 17,
    parameter int COLS               = 4,
    parameter int ROWS               = 3,
    parameter int TILE_W             = 100,
    parameter int TILE_H             = 100,
    parameter int PITCH_X            = 128,
    parameter int PITCH_Y            = 128,
    parameter int ORIGIN_X           = 308,
    parameter int ORIGIN_Y           = 20,
    parameter int IND_SIZE           = 10,
    parameter int BLINK_FRAMES       = 30
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [CNTR_WIDTH_H-1:0]       CounterX,
    input  logic [CNTR_WIDTH_V-1:0]       CounterY,
    input  logic [COLS*ROWS-1:0]          HighlightMask,
    input  logic                          BlinkEn,
    output logic [ROM_ADDR_BUS_WIDTH-1:0] ROM_Addr,
    output logic [7:0]                    TileID,
    output logic                          isImage,
    output logic                          inHighlightedArea
);
    localparam int AW        = ROM_ADDR_BUS_WIDTH;
    localparam int NT        = COLS * ROWS;
    localparam int TILE_AREA = TILE_W * TILE_H;
    localparam int LX_W      = $clog2(TILE_W + 1);
    localparam int LY_W      = $clog2(TILE_H + 1);
    localparam int LO_W      = (TILE_AREA > 1) ? $clog2(TILE_AREA) : 1;
    localparam int BC_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [31:0]     w_x, w_y;
    logic            w_col_hit, w_row_hit, w_hit;
    logic [3:0]      w_col, w_row;
    logic [LX_W-1:0] w_lx;
    logic [LY_W-1:0] w_ly;
    logic            w_band_first, w_band_in;
    logic [7:0]      w_tid;
    logic            w_mask_bit, w_ind;
    logic            w_line_start, w_frame_start;

    logic [LO_W-1:0] r_line_off, w_line_off_nxt;
    logic [BC_W-1:0] r_blink_cnt, w_blink_cnt_nxt;
    logic            r_blink_phase, w_blink_phase_nxt;
    logic            r_synced, w_synced_nxt;

    logic            r_hit, r_vld, r_hl;
    logic [7:0]      r_tid;
    logic [LX_W-1:0] r_lx;
    logic [AW-1:0]   w_base, w_addr;

    assign w_x           = 32'(CounterX);
    assign w_y           = 32'(CounterY);
    assign w_line_start  = (CounterX == '0);
    assign w_frame_start = w_line_start && (CounterY == '0);

    always_comb begin
        w_col_hit = 1'b0;
        w_col     = '0;
        w_lx      = '0;
        for (int c = 0; c < COLS; c++) begin
            if (w_x >= 32'(ORIGIN_X + c*PITCH_X) && w_x <= 32'(ORIGIN_X + c*PITCH_X + TILE_W - 1)) begin
                w_col_hit = 1'b1;
                w_col     = 4'(c);
                w_lx      = LX_W'(w_x - 32'(ORIGIN_X + c*PITCH_X));
            end
        end
    end

    always_comb begin
        w_row_hit    = 1'b0;
        w_row        = '0;
        w_ly         = '0;
        w_band_first = 1'b0;
        w_band_in    = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (w_y >= 32'(ORIGIN_Y + r*PITCH_Y) && w_y <= 32'(ORIGIN_Y + r*PITCH_Y + TILE_H - 1)) begin
                w_row_hit    = 1'b1;
                w_row        = 4'(r);
                w_ly         = LY_W'(w_y - 32'(ORIGIN_Y + r*PITCH_Y));
                w_band_first = (w_y == 32'(ORIGIN_Y + r*PITCH_Y));
                w_band_in    = (w_y != 32'(ORIGIN_Y + r*PITCH_Y));
            end
        end
    end

    assign w_hit = w_col_hit & w_row_hit;
    assign w_tid = 8'(w_row) * 8'(COLS) + 8'(w_col);
    assign w_ind = (32'(w_lx) < 32'(IND_SIZE)) && (32'(w_ly) < 32'(IND_SIZE));

    always_comb begin
        w_mask_bit = 1'b0;
        for (int t = 0; t < NT; t++)
            if (w_tid == 8'(t)) w_mask_bit = HighlightMask[t];
    end

    // Frame/line bookkeeping; the frame-start pixel already sees the updated blink phase.
    always_comb begin
        w_line_off_nxt    = r_line_off;
        w_blink_cnt_nxt   = r_blink_cnt;
        w_blink_phase_nxt = r_blink_phase;
        w_synced_nxt      = r_synced | w_frame_start;
        if (w_line_start) begin
            if (w_band_first)   w_line_off_nxt = '0;
            else if (w_band_in) w_line_off_nxt = r_line_off + LO_W'(TILE_W);
        end
        if (w_frame_start) begin
            if (r_blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
                w_blink_cnt_nxt   = '0;
                w_blink_phase_nxt = ~r_blink_phase;
            end else begin
                w_blink_cnt_nxt   = r_blink_cnt + BC_W'(1);
            end
        end
    end

    always_comb begin
        w_base = '0;
        for (int t = 0; t < NT; t++)
            if (r_tid == 8'(t)) w_base = AW'(t * TILE_AREA);
    end

    assign w_addr = w_base + AW'(r_line_off) + AW'(r_lx);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_line_off        <= '0;
            r_blink_cnt       <= '0;
            r_blink_phase     <= 1'b1;
            r_synced          <= 1'b0;
            r_hit             <= 1'b0;
            r_vld             <= 1'b0;
            r_hl              <= 1'b0;
            r_tid             <= '0;
            r_lx              <= '0;
            ROM_Addr          <= '0;
            TileID            <= '0;
            isImage           <= 1'b0;
            inHighlightedArea <= 1'b0;
        end else begin
            r_line_off        <= w_line_off_nxt;
            r_blink_cnt       <= w_blink_cnt_nxt;
            r_blink_phase     <= w_blink_phase_nxt;
            r_synced          <= w_synced_nxt;
            r_hit             <= w_hit;
            r_vld             <= w_synced_nxt;
            r_hl              <= w_ind & w_mask_bit & (~BlinkEn | w_blink_phase_nxt);
            r_tid             <= w_hit ? w_tid : 8'd0;
            r_lx              <= w_lx;
            ROM_Addr          <= (r_hit & r_vld) ? w_addr : '0;
            TileID            <= r_tid;
            isImage           <= r_hit & r_vld;
            inHighlightedArea <= r_hit & r_vld & r_hl;
        end
    end
endmodule

// File: tb/tb_grid_tile_locator.sv
// Scoreboard bench for grid_tile_locator: default-geometry instance plus a small 2x2 instance.
module tb_grid_tile_locator;
    typedef struct {
        int cols, rows, tw, th, px, py, ox, oy, ind, bf;
    } geo_t;

    typedef struct {
        int x, y, addr, tid;
        bit img, hl;
    } exp_t;

    logic        clk, rst;
    logic [10:0] cx_a, cx_b;
    logic [9:0]  cy_a, cy_b;
    logic [11:0] mask_a;
    logic [3:0]  mask_b;
    logic        ben_a, ben_b;
    logic [16:0] rom_a, rom_b;
    logic [7:0]  tid_a, tid_b;
    logic        img_a, img_b, hl_a, hl_b;

    geo_t ga, gb;
    exp_t qa[$], qb[$];
    exp_t ea, eb;
    bit   act_a, act_b, ha1, ha2, hb1, hb2;
    bit   m_sync[2];
    int   m_nfs[2];
    int   hits[128];
    bit   b_open;
    int   n_chk, n_fail;

    grid_tile_locator dut_a (
        .CLK(clk), .RST(rst), .CounterX(cx_a), .CounterY(cy_a),
        .HighlightMask(mask_a), .BlinkEn(ben_a),
        .ROM_Addr(rom_a), .TileID(tid_a), .isImage(img_a), .inHighlightedArea(hl_a)
    );

    grid_tile_locator #(
        .COLS(2), .ROWS(2), .TILE_W(8), .TILE_H(4), .PITCH_X(10), .PITCH_Y(10),
        .ORIGIN_X(0), .ORIGIN_Y(0), .IND_SIZE(3), .BLINK_FRAMES(2)
    ) dut_b (
        .CLK(clk), .RST(rst), .CounterX(cx_b), .CounterY(cy_b),
        .HighlightMask(mask_b), .BlinkEn(ben_b),
        .ROM_Addr(rom_b), .TileID(tid_b), .isImage(img_b), .inHighlightedArea(hl_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int x, input int y, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at (%0d,%0d): got %0d, expected %0d", nm, x, y, got, exp);
        end
    endtask

    // Reference: geometry straight from tile rectangles; blink phase flips every bf frame starts.
    function automatic exp_t model(input geo_t g, input int x, input int y, input int msk,
                                   input bit be, input bit synced, input int nfs);
        exp_t e;
        int l, t, id;
        e.x = x; e.y = y; e.addr = 0; e.tid = 0; e.img = 0; e.hl = 0;
        for (int r = 0; r < g.rows; r++) begin
            for (int c = 0; c < g.cols; c++) begin
                l = g.ox + c * g.px;
                t = g.oy + r * g.py;
                if (x >= l && x < l + g.tw && y >= t && y < t + g.th) begin
                    id    = r * g.cols + c;
                    e.tid = id;
                    if (synced) begin
                        e.img  = 1;
                        e.addr = id * g.tw * g.th + (y - t) * g.tw + (x - l);
                        e.hl   = (x - l < g.ind) && (y - t < g.ind) && msk[id]
                                 && (!be || ((nfs / g.bf) % 2 == 0));
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic drive(input int sel, input int x, input int y, input int msk, input bit be);
        exp_t e;
        @(negedge clk);
        if (sel == 0) begin
            cx_a = 11'(x); cy_a = 10'(y); mask_a = 12'(msk); ben_a = be;
            act_a = 1'b1; act_b = 1'b0;
        end else begin
            cx_b = 11'(x); cy_b = 10'(y); mask_b = 4'(msk); ben_b = be;
            act_a = 1'b0; act_b = 1'b1;
        end
        if (x == 0 && y == 0) begin
            m_sync[sel] = 1'b1;
            m_nfs[sel]++;
        end
        if (sel == 0) begin
            e = model(ga, x, y, msk, be, m_sync[0], m_nfs[0]);
            qa.push_back(e);
        end else begin
            e = model(gb, x, y, msk, be, m_sync[1], m_nfs[1]);
            qb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        act_a = 1'b0; act_b = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Scan rows (each starting at x=0) and pixels xlo..xhi on rows ylo..yhi.
    task automatic scan_a(input int ylo, input int yhi, input int xlo, input int xhi,
                          input bit rnd, input bit fs, input int msk, input bit be);
        int m; bit b;
        m = msk; b = be;
        for (int y = (fs ? 0 : ylo); y <= yhi; y++) begin
            if (rnd) begin m = int'($urandom_range(4095, 0)); b = 1'($urandom); end
            drive(0, 0, y, m, b);
            if (y >= ylo) begin
                for (int x = xlo; x <= xhi; x++) begin
                    if (rnd) begin m = int'($urandom_range(4095, 0)); b = 1'($urandom); end
                    drive(0, x, y, m, b);
                end
            end
        end
    endtask

    task automatic frame_b(input bit rnd, input int msk, input bit be);
        int m; bit b;
        m = msk; b = be;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 24; x++) begin
                if (rnd) begin m = int'($urandom_range(15, 0)); b = 1'($urandom); end
                drive(1, x, y, m, b);
            end
        end
    endtask

    task automatic check_reset();
        cmp("rst_rom_a", -1, -1, int'(rom_a), 0);
        cmp("rst_tid_a", -1, -1, int'(tid_a), 0);
        cmp("rst_img_a", -1, -1, int'(img_a), 0);
        cmp("rst_hl_a",  -1, -1, int'(hl_a),  0);
        cmp("rst_rom_b", -1, -1, int'(rom_b), 0);
        cmp("rst_tid_b", -1, -1, int'(tid_b), 0);
        cmp("rst_img_b", -1, -1, int'(img_b), 0);
        cmp("rst_hl_b",  -1, -1, int'(hl_b),  0);
    endtask

    always @(posedge clk) begin
        ha2 = ha1; ha1 = act_a;
        #1;
        if (ha2) begin
            if (qa.size() == 0) begin
                cmp("a_queue_empty", -1, -1, 1, 0);
            end else begin
                ea = qa.pop_front();
                cmp("a_rom", ea.x, ea.y, int'(rom_a), ea.addr);
                cmp("a_tid", ea.x, ea.y, int'(tid_a), ea.tid);
                cmp("a_img", ea.x, ea.y, int'(img_a), int'(ea.img));
                cmp("a_hl",  ea.x, ea.y, int'(hl_a),  int'(ea.hl));
            end
        end
    end

    always @(posedge clk) begin
        int bad;
        hb2 = hb1; hb1 = act_b;
        #1;
        if (hb2) begin
            if (qb.size() == 0) begin
                cmp("b_queue_empty", -1, -1, 1, 0);
            end else begin
                eb = qb.pop_front();
                if (eb.x == 0 && eb.y == 0) begin
                    if (b_open) begin
                        bad = 0;
                        for (int i = 0; i < 128; i++) if (hits[i] != 1) bad++;
                        cmp("b_addr_cover", eb.x, eb.y, bad, 0);
                    end
                    for (int i = 0; i < 128; i++) hits[i] = 0;
                    b_open = 1'b1;
                end
                cmp("b_rom", eb.x, eb.y, int'(rom_b), eb.addr);
                cmp("b_tid", eb.x, eb.y, int'(tid_b), eb.tid);
                cmp("b_img", eb.x, eb.y, int'(img_b), int'(eb.img));
                cmp("b_hl",  eb.x, eb.y, int'(hl_b),  int'(eb.hl));
                if (img_b) begin
                    if (rom_b < 17'd128) hits[rom_b]++;
                    else hits[0] += 2;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ga = '{cols:4, rows:3, tw:100, th:100, px:128, py:128, ox:308, oy:20, ind:10, bf:30};
        gb = '{cols:2, rows:2, tw:8,   th:4,   px:10,  py:10,  ox:0,   oy:0,  ind:3,  bf:2};
        n_chk = 0; n_fail = 0; b_open = 1'b0;
        act_a = 1'b0; act_b = 1'b0; ha1 = 0; ha2 = 0; hb1 = 0; hb2 = 0;
        m_sync[0] = 0; m_sync[1] = 0; m_nfs[0] = 0; m_nfs[1] = 0;
        cx_a = 11'd1000; cy_a = 10'd500; mask_a = '0; ben_a = 1'b0;
        cx_b = 11'd1;    cy_b = 10'd15;  mask_b = '0; ben_b = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset();
        rst = 1'b0;

        // Before any frame start: everything gated off
        scan_a(18, 24, 300, 320, 1'b0, 1'b0, 12'h021, 1'b0);

        // Directed points and indicator corners
        scan_a(20, 20, 308, 308, 1'b0, 1'b1, 12'h021, 1'b0);
        scan_a(119, 119, 407, 408, 1'b0, 1'b1, 12'h021, 1'b0);
        scan_a(151, 151, 437, 437, 1'b0, 1'b1, 12'h021, 1'b0);
        scan_a(375, 375, 692, 692, 1'b0, 1'b1, 12'h021, 1'b0);
        scan_a(20, 31, 306, 320, 1'b0, 1'b1, 12'h021, 1'b0);
        scan_a(148, 160, 434, 448, 1'b0, 1'b1, 12'h021, 1'b0);
        scan_a(60, 100, 300, 340, 1'b0, 1'b1, 12'hfff, 1'b0);

        // Reset pulse in the middle of a frame
        idle(3);
        rst = 1'b1;
        #1;
        check_reset();
        m_sync[0] = 0; m_sync[1] = 0; m_nfs[0] = 0; m_nfs[1] = 0;
        @(negedge clk);
        rst = 1'b0;
        scan_a(100, 130, 300, 420, 1'b1, 1'b0, 0, 1'b0);

        // Randomised partial frames; frame starts also advance the blink counter
        for (int k = 0; k < 40; k++) begin
            int yhi, ylo, xlo;
            yhi = int'($urandom_range(400, 0));
            ylo = yhi - int'($urandom_range(4, 0));
            if (ylo < 0) ylo = 0;
            xlo = int'($urandom_range(760, 290));
            scan_a(ylo, yhi, xlo, xlo + 40, 1'b1, 1'b1, 0, 1'b0);
        end

        // Small grid: blink with fixed mask, then random mask/blink, full frames
        for (int f = 0; f < 6; f++) frame_b(1'b0, 4'h1, 1'b1);
        for (int f = 0; f < 4; f++) frame_b(1'b1, 0, 1'b0);
        drive(1, 0, 0, 4'h1, 1'b0);

        idle(4);
        cmp("queues_drained", -1, -1, qa.size() + qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
